// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - parametrised multi-port register file with two prioritised write ports
module regfile_mp #(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter int NR      = 3,
    parameter int ZERO_R0 = 1,
    parameter int BYPASS  = 1
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic [NR*AW-1:0]   rn,
    output logic [NR*DW-1:0]   q,
    input  logic [AW-1:0]      wna,
    input  logic [DW-1:0]      da,
    input  logic               wea,
    input  logic [AW-1:0]      wnb,
    input  logic [DW-1:0]      db,
    input  logic               web
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] regs [DEPTH];

    if (NR < 1) begin : g_nr_check
        $error("regfile_mp: NR must be at least 1");
    end

    // Address 0 is a constant zero when ZERO_R0 is set: never stored, never bypassed.
    function automatic logic is_live(input logic [AW-1:0] a);
        return !((ZERO_R0 != 0) && (a == '0));
    endfunction

    // Port B is applied last so it wins a same-address collision.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            if (wea && is_live(wna)) begin
                regs[wna] <= da;
            end
            if (web && is_live(wnb)) begin
                regs[wnb] <= db;
            end
        end
    end

    for (genvar g = 0; g < NR; g++) begin : g_rd
        logic [AW-1:0] ra;
        logic [DW-1:0] qi;

        assign ra = rn[g*AW +: AW];

        // Bypass order mirrors write priority so q before the edge equals reg after it.
        always_comb begin
            qi = '0;
            if (!clrn || !is_live(ra)) begin
                qi = '0;
            end else if ((BYPASS != 0) && web && (wnb == ra)) begin
                qi = db;
            end else if ((BYPASS != 0) && wea && (wna == ra)) begin
                qi = da;
            end else begin
                qi = regs[ra];
            end
        end

        assign q[g*DW +: DW] = qi;
    end
endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - scoreboard bench for regfile_mp across three parameter sets
module tb_regfile_mp;
    logic clk = 1'b0;
    logic clrn;

    // u0: defaults (DW32 AW5 NR3 ZERO_R0=1 BYPASS=1)
    logic [14:0] rn0;
    logic [95:0] q0;
    logic [4:0]  wna0, wnb0;
    logic [31:0] da0, db0;
    logic        wea0, web0;

    // u1: NR2 ZERO_R0=0 BYPASS=0
    logic [9:0]  rn1;
    logic [63:0] q1;
    logic [4:0]  wna1, wnb1;
    logic [31:0] da1, db1;
    logic        wea1, web1;

    // u2: DW16 AW3 NR4 ZERO_R0=0 BYPASS=1
    logic [11:0] rn2;
    logic [63:0] q2;
    logic [2:0]  wna2, wnb2;
    logic [15:0] da2, db2;
    logic        wea2, web2;

    regfile_mp u0 (.clk(clk), .clrn(clrn), .rn(rn0), .q(q0), .wna(wna0), .da(da0), .wea(wea0),
                   .wnb(wnb0), .db(db0), .web(web0));
    regfile_mp #(.NR(2), .ZERO_R0(0), .BYPASS(0)) u1 (.clk(clk), .clrn(clrn), .rn(rn1), .q(q1),
                   .wna(wna1), .da(da1), .wea(wea1), .wnb(wnb1), .db(db1), .web(web1));
    regfile_mp #(.DW(16), .AW(3), .NR(4), .ZERO_R0(0), .BYPASS(1)) u2 (.clk(clk), .clrn(clrn),
                   .rn(rn2), .q(q2), .wna(wna2), .da(da2), .wea(wea2), .wnb(wnb2), .db(db2), .web(web2));

    always #5 clk = ~clk;

    typedef struct {
        int          inst;
        int          port;
        logic [31:0] exp;
        string       name;
    } sb_t;

    sb_t sb[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    function automatic logic [31:0] actual(input int inst, input int port);
        case (inst)
            0:       return q0[port*32 +: 32];
            1:       return q1[port*32 +: 32];
            default: return {16'h0, q2[port*16 +: 16]};
        endcase
    endfunction

    // Monitor: combinational outputs are presented every cycle; sample on the falling edge.
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            sb_t e;
            logic [31:0] a;
            e = sb.pop_front();
            a = actual(e.inst, e.port);
            n_tests++;
            if (a !== e.exp) begin
                n_fail++;
                $display("FAIL %s u%0d q[%0d] got %h expected %h", e.name, e.inst, e.port, a, e.exp);
            end
        end
    end

    task automatic expect_q(input int inst, input int port, input logic [31:0] exp, input string name);
        sb_t e;
        e.inst = inst; e.port = port; e.exp = exp; e.name = name;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
        wea0 = 0; web0 = 0; wea1 = 0; web1 = 0; wea2 = 0; web2 = 0;
    endtask

    task automatic rd0(input logic [4:0] a, input logic [4:0] b, input logic [4:0] c);
        rn0 = {c, b, a};
    endtask

    initial begin
        clrn = 0;
        rn0 = '0; wna0 = '0; wnb0 = '0; da0 = '0; db0 = '0; wea0 = 0; web0 = 0;
        rn1 = '0; wna1 = '0; wnb1 = '0; da1 = '0; db1 = '0; wea1 = 0; web1 = 0;
        rn2 = '0; wna2 = '0; wnb2 = '0; da2 = '0; db2 = '0; wea2 = 0; web2 = 0;

        cyc();
        rd0(1, 7, 31);
        expect_q(0, 0, 0, "reset_r1"); expect_q(0, 2, 0, "reset_r31");
        expect_q(1, 0, 0, "reset_u1");

        cyc(); clrn = 1;
        cyc();
        wea0 = 1; wna0 = 1; da0 = 32'h0000_000F; web0 = 1; wnb0 = 7; db0 = 32'hDEAD_BEEF;
        rd0(1, 7, 2);
        expect_q(0, 0, 32'h0000_000F, "byp_a"); expect_q(0, 1, 32'hDEAD_BEEF, "byp_b");
        expect_q(0, 2, 0, "byp_other");
        cyc();
        rd0(1, 7, 1);
        expect_q(0, 0, 32'h0000_000F, "wr_r1"); expect_q(0, 1, 32'hDEAD_BEEF, "wr_r7");
        expect_q(0, 2, 32'h0000_000F, "wr_r1_dup");

        // Reset asserted between edges, with a write pending: reads go to 0 at once.
        cyc();
        clrn = 0; wea0 = 1; wna0 = 1; da0 = 32'h77;
        expect_q(0, 0, 0, "async_clr_r1"); expect_q(0, 1, 0, "async_clr_r7");
        cyc();
        wea0 = 1; wna0 = 1; da0 = 32'h77;
        expect_q(0, 0, 0, "clr_hold_r1");
        cyc(); clrn = 1;
        rd0(1, 7, 0);
        expect_q(0, 0, 0, "clr_wr_ignored"); expect_q(0, 1, 0, "clr_r7");
        cyc();
        wea0 = 1; wna0 = 1; da0 = 32'h5;
        expect_q(0, 0, 32'h5, "post_rst_byp");
        cyc();
        expect_q(0, 0, 32'h5, "post_rst_r1"); expect_q(0, 1, 0, "post_rst_r7");

        // Dual write, distinct addresses
        cyc();
        wea0 = 1; wna0 = 3; da0 = 32'h11; web0 = 1; wnb0 = 4; db0 = 32'h22;
        rd0(3, 4, 3);
        expect_q(0, 0, 32'h11, "dual_byp0"); expect_q(0, 1, 32'h22, "dual_byp1");
        expect_q(0, 2, 32'h11, "dual_byp2");
        cyc();
        expect_q(0, 0, 32'h11, "dual_r3"); expect_q(0, 1, 32'h22, "dual_r4");
        expect_q(0, 2, 32'h11, "dual_r3b");

        // Collision: port B wins
        cyc();
        wea0 = 1; wna0 = 5; da0 = 32'hAAAA; web0 = 1; wnb0 = 5; db0 = 32'hBBBB;
        wea1 = 1; wna1 = 5; da1 = 32'hAAAA; web1 = 1; wnb1 = 5; db1 = 32'hBBBB;
        rd0(5, 5, 6); rn1 = {5'd5, 5'd5};
        expect_q(0, 0, 32'hBBBB, "coll_byp"); expect_q(0, 2, 0, "coll_other");
        expect_q(1, 0, 0, "coll_nobyp");
        cyc();
        expect_q(0, 0, 32'hBBBB, "coll_r5"); expect_q(1, 1, 32'hBBBB, "coll_r5_u1");

        // Register zero via port B, then via port A
        cyc();
        web0 = 1; wnb0 = 0; db0 = 32'hFFFF_FFFF; web1 = 1; wnb1 = 0; db1 = 32'hFFFF_FFFF;
        rd0(0, 0, 0); rn1 = {5'd0, 5'd0};
        expect_q(0, 0, 0, "r0b_byp0"); expect_q(0, 2, 0, "r0b_byp2");
        expect_q(1, 0, 0, "r0b_u1_pre");
        cyc();
        expect_q(0, 1, 0, "r0b_post"); expect_q(1, 0, 32'hFFFF_FFFF, "r0b_u1_post");
        cyc();
        wea0 = 1; wna0 = 0; da0 = 32'h1234_5678; wea1 = 1; wna1 = 0; da1 = 32'h1234_5678;
        expect_q(0, 0, 0, "r0a_byp"); expect_q(1, 1, 32'hFFFF_FFFF, "r0a_u1_pre");
        cyc();
        expect_q(0, 0, 0, "r0a_post"); expect_q(1, 1, 32'h1234_5678, "r0a_u1_post");

        // Bypass vs no bypass
        cyc();
        wea0 = 1; wna0 = 9; da0 = 32'h1; wea1 = 1; wna1 = 9; da1 = 32'h1;
        cyc();
        rd0(9, 0, 0); rn1 = {5'd0, 5'd9};
        expect_q(0, 0, 32'h1, "r9_init"); expect_q(1, 0, 32'h1, "r9_init_u1");
        cyc();
        wea0 = 1; wna0 = 9; da0 = 32'h2; wea1 = 1; wna1 = 9; da1 = 32'h2;
        expect_q(0, 0, 32'h2, "byp_on_pre"); expect_q(1, 0, 32'h1, "byp_off_pre");
        cyc();
        expect_q(0, 0, 32'h2, "byp_on_post"); expect_q(1, 0, 32'h2, "byp_off_post");

        // Parameter sweep on u2: fill with 0x100+i, alternating write ports
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i % 2 == 0) begin
                wea2 = 1; wna2 = 3'(i); da2 = 16'(16'h100 + i);
            end else begin
                web2 = 1; wnb2 = 3'(i); db2 = 16'(16'h100 + i);
            end
            rn2 = {4{3'(i)}};
            expect_q(2, 3, 32'(16'h100 + i), "sweep_byp");
        end
        for (int c = 0; c < 4096; c++) begin
            cyc();
            rn2 = 12'(c);
            for (int p = 0; p < 4; p++) begin
                expect_q(2, p, 32'h100 + ((c >> (3*p)) & 7), "sweep_rd");
            end
        end

        @(negedge clk);
        #1;
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left %0d expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
